wb_cache_ctrl: RTL and testbench

Parametrised direct-mapped, write-back, write-allocate cache controller sitting between a CPU load/store port and a line-wide memory port. Unlike the single-cycle write-through predecessor, it uses a ready/valid CPU handshake and a req/ack memory handshake with arbitrary memory latency. It tracks dirty lines and evicts them before refill, and it derives tag, index and offset widths from parameters.

---
 rtl/cache_pkg.sv | 34 +++
 rtl/cache_line_store.sv | 58 +++++
 rtl/wb_cache_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_wb_cache_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
//------------------------------------------------------------------------------
// cache_pkg : shared types and field-width helpers for the write-back cache.
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } cache_state_t;

    function automatic int offset_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - index_w(sets) - offset_w(line_words);
    endfunction

    // Width of the word-within-line selector; kept at least 1 bit for single-word lines.
    function automatic int wsel_w(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_line_store.sv
//------------------------------------------------------------------------------
// cache_line_store : data/tag/valid/dirty arrays, one async read and one write port.
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cache_line_store #(
    parameter int SETS    = 1024,
    parameter int LINE_W  = 128,
    parameter int TAG_W   = 18,
    parameter int INDEX_W = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INDEX_W-1:0] i_rd_index,
    output logic [LINE_W-1:0]  o_rd_data,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic               o_rd_valid,
    output logic               o_rd_dirty,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [LINE_W-1:0]  i_wr_data,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic               i_wr_valid,
    input  logic               i_wr_dirty
);

    logic [LINE_W-1:0] r_data [SETS];
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [SETS-1:0]   r_valid;
    logic [SETS-1:0]   r_dirty;

    // Payload arrays carry no reset so they can map onto RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[i_wr_index] <= i_wr_data;
            r_tag[i_wr_index]  <= i_wr_tag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= i_wr_valid;
            r_dirty[i_wr_index] <= i_wr_dirty;
        end
    end

    assign o_rd_data  = r_data[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_dirty = r_dirty[i_rd_index];

endmodule

`default_nettype wire

// File: rtl/wb_cache_ctrl.sv
//------------------------------------------------------------------------------
// wb_cache_ctrl : direct-mapped write-back/write-allocate cache controller.
//                 Statistics counters enabled by defining CACHE_STATS_EN.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 1024,
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cpu_req,
    input  logic                     cpu_write,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [31:0]              cpu_write_data,
    output logic                     cpu_ready,
    output logic                     cpu_rvalid,
    output logic [31:0]              cpu_read_data,
    output logic                     hit,
    output logic                     miss,
    output logic                     mem_req,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [32*LINE_WORDS-1:0] mem_write_data,
    input  logic                     mem_ack,
    input  logic [32*LINE_WORDS-1:0] mem_read_data,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count,
    output logic [31:0]              wb_count
);

    localparam int C_LINE_W   = 32 * LINE_WORDS;
    localparam int C_OFFSET_W = offset_w(LINE_WORDS);
    localparam int C_INDEX_W  = index_w(SETS);
    localparam int C_TAG_W    = tag_w(ADDR_W, SETS, LINE_WORDS);
    localparam int C_WSEL_W   = wsel_w(LINE_WORDS);

    typedef logic [LINE_WORDS-1:0][31:0] line_t;

    cache_state_t         r_state, w_state_next;
    logic                 r_write;
    logic [31:0]          r_wdata;
    logic [C_TAG_W-1:0]   r_tag;
    logic [C_INDEX_W-1:0] r_index;
    logic [C_WSEL_W-1:0]  r_wsel;

    logic [C_TAG_W-1:0]   w_tag_in;
    logic [C_INDEX_W-1:0] w_index_in;
    logic [C_WSEL_W-1:0]  w_wsel_in;
    logic                 w_accept;
    logic                 w_unused;

    logic [C_INDEX_W-1:0] w_rd_index;
    line_t                w_rd_line;
    logic [C_TAG_W-1:0]   w_rd_tag;
    logic                 w_rd_valid, w_rd_dirty;
    logic                 w_lookup_hit;
    line_t                w_mem_line;

    logic                 w_wr_en, w_wr_valid, w_wr_dirty;
    logic [C_INDEX_W-1:0] w_wr_index;
    logic [C_TAG_W-1:0]   w_wr_tag;
    line_t                w_wr_line;

    logic                 w_hit_d, w_miss_d, w_rvalid_d, w_mem_req_d, w_mem_write_d;
    logic [31:0]          w_rdata_d;
    logic [ADDR_W-1:0]    w_mem_addr_d;
    logic [C_LINE_W-1:0]  w_mem_wdata_d;

    assign w_tag_in   = cpu_addr[ADDR_W-1 -: C_TAG_W];
    assign w_index_in = cpu_addr[C_OFFSET_W +: C_INDEX_W];
    assign w_unused   = ^cpu_addr[1:0];

    generate
        if (LINE_WORDS > 1) begin : g_wsel_multi
            assign w_wsel_in = cpu_addr[C_OFFSET_W-1:2];
        end else begin : g_wsel_single
            assign w_wsel_in = '0;
        end
    endgenerate

    assign cpu_ready    = (r_state == ST_IDLE);
    assign w_accept     = cpu_req && cpu_ready;
    // In IDLE the lookup uses the live address so the result registers at acceptance.
    assign w_rd_index   = (r_state == ST_IDLE) ? w_index_in : r_index;
    assign w_lookup_hit = w_rd_valid && (w_rd_tag == w_tag_in);
    assign w_mem_line   = mem_read_data;

    cache_line_store #(
        .SETS    (SETS),
        .LINE_W  (C_LINE_W),
        .TAG_W   (C_TAG_W),
        .INDEX_W (C_INDEX_W)
    ) u_store (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_rd_index (w_rd_index),
        .o_rd_data  (w_rd_line),
        .o_rd_tag   (w_rd_tag),
        .o_rd_valid (w_rd_valid),
        .o_rd_dirty (w_rd_dirty),
        .i_wr_en    (w_wr_en),
        .i_wr_index (w_wr_index),
        .i_wr_data  (w_wr_line),
        .i_wr_tag   (w_wr_tag),
        .i_wr_valid (w_wr_valid),
        .i_wr_dirty (w_wr_dirty)
    );

    always_comb begin
        w_state_next  = r_state;
        w_hit_d       = 1'b0;
        w_miss_d      = 1'b0;
        w_rvalid_d    = 1'b0;
        w_rdata_d     = cpu_read_data;
        w_mem_req_d   = mem_req;
        w_mem_write_d = mem_write;
        w_mem_addr_d  = mem_addr;
        w_mem_wdata_d = mem_write_data;
        w_wr_en       = 1'b0;
        w_wr_index    = r_index;
        w_wr_tag      = r_tag;
        w_wr_valid    = 1'b1;
        w_wr_dirty    = 1'b0;
        w_wr_line     = w_rd_line;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_lookup_hit) begin
                        w_hit_d    = 1'b1;
                        w_rvalid_d = 1'b1;
                        if (cpu_write) begin
                            w_wr_en              = 1'b1;
                            w_wr_index           = w_index_in;
                            w_wr_tag             = w_rd_tag;
                            w_wr_dirty           = 1'b1;
                            w_wr_line[w_wsel_in] = cpu_write_data;
                        end else begin
                            w_rdata_d = w_rd_line[w_wsel_in];
                        end
                    end else begin
                        w_miss_d    = 1'b1;
                        w_mem_req_d = 1'b1;
                        if (w_rd_valid && w_rd_dirty) begin
                            w_state_next  = ST_WRITEBACK;
                            w_mem_write_d = 1'b1;
                            w_mem_addr_d  = {w_rd_tag, w_index_in, {C_OFFSET_W{1'b0}}};
                            w_mem_wdata_d = w_rd_line;
                        end else begin
                            w_state_next  = ST_REFILL;
                            w_mem_write_d = 1'b0;
                            w_mem_addr_d  = {w_tag_in, w_index_in, {C_OFFSET_W{1'b0}}};
                        end
                    end
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack) begin
                    // Rewrite the victim unchanged except for a cleared dirty bit.
                    w_wr_en       = 1'b1;
                    w_wr_tag      = w_rd_tag;
                    w_state_next  = ST_REFILL;
                    w_mem_write_d = 1'b0;
                    w_mem_addr_d  = {r_tag, r_index, {C_OFFSET_W{1'b0}}};
                end
            end
            ST_REFILL: begin
                if (mem_ack) begin
                    w_wr_en    = 1'b1;
                    w_wr_dirty = r_write;
                    w_wr_line  = w_mem_line;
                    if (r_write) begin
                        w_wr_line[r_wsel] = r_wdata;
                    end
                    w_rdata_d    = w_mem_line[r_wsel];
                    w_rvalid_d   = 1'b1;
                    w_mem_req_d  = 1'b0;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write        <= 1'b0;
            r_wdata        <= '0;
            r_tag          <= '0;
            r_index        <= '0;
            r_wsel         <= '0;
            cpu_rvalid     <= 1'b0;
            cpu_read_data  <= '0;
            hit            <= 1'b0;
            miss           <= 1'b0;
            mem_req        <= 1'b0;
            mem_write      <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            if (w_accept) begin
                r_write <= cpu_write;
                r_wdata <= cpu_write_data;
                r_tag   <= w_tag_in;
                r_index <= w_index_in;
                r_wsel  <= w_wsel_in;
            end
            cpu_rvalid     <= w_rvalid_d;
            cpu_read_data  <= w_rdata_d;
            hit            <= w_hit_d;
            miss           <= w_miss_d;
            mem_req        <= w_mem_req_d;
            mem_write      <= w_mem_write_d;
            mem_addr       <= w_mem_addr_d;
            mem_write_data <= w_mem_wdata_d;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_count, r_miss_count, r_wb_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else begin
            if (hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
            if ((r_state == ST_WRITEBACK) && mem_ack) begin
                r_wb_count <= r_wb_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
    assign wb_count   = r_wb_count;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_cache_ctrl.sv
//------------------------------------------------------------------------------
// tb_wb_cache_ctrl : directed self-checking bench for wb_cache_ctrl.
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_cache_ctrl;

`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cpu_req = 1'b0;
    logic         cpu_write = 1'b0;
    logic [31:0]  cpu_addr = '0;
    logic [31:0]  cpu_write_data = '0;
    logic         cpu_ready, cpu_rvalid, hit, miss, mem_req, mem_write;
    logic [31:0]  cpu_read_data, mem_addr;
    logic [127:0] mem_write_data;
    logic         mem_ack = 1'b0;
    logic [127:0] mem_read_data = '0;
    logic [31:0]  hit_count, miss_count, wb_count;

    int n_checks = 0;
    int n_errors = 0;

    wb_cache_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_req        (cpu_req),
        .cpu_write      (cpu_write),
        .cpu_addr       (cpu_addr),
        .cpu_write_data (cpu_write_data),
        .cpu_ready      (cpu_ready),
        .cpu_rvalid     (cpu_rvalid),
        .cpu_read_data  (cpu_read_data),
        .hit            (hit),
        .miss           (miss),
        .mem_req        (mem_req),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_ack        (mem_ack),
        .mem_read_data  (mem_read_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count),
        .wb_count       (wb_count)
    );

    always #5 clk = ~clk;

    // Line memory: unwritten lines hold each word's own byte address.
    logic [127:0] mem_model [logic [31:0]];
    int mem_wait = 3;
    int wait_cnt = 0;

    function automatic logic [127:0] line_at(input logic [31:0] a);
        logic [127:0] l;
        if (mem_model.exists(a)) return mem_model[a];
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = a + 32'(w * 4);
        return l;
    endfunction

    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (!reset_n || !mem_req) begin
            wait_cnt = 0;
        end else if (wait_cnt == mem_wait) begin
            mem_ack = 1'b1;
            if (mem_write) mem_model[mem_addr] = mem_write_data;
            mem_read_data = line_at(mem_addr);
            wait_cnt = 0;
        end else begin
            wait_cnt++;
        end
    end

    int acc_count = 0;
    int rv_count  = 0;
    always @(posedge clk) begin
        if (reset_n && cpu_req && cpu_ready) acc_count++;
        if (cpu_rvalid) rv_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic         o_hit, o_miss, o_got, o_any_req, o_any_write, o_c1_req, o_c1_write;
    logic [31:0]  o_c1_addr, o_rf_addr, o_rdata;
    logic [127:0] o_c1_wdata;
    int           o_lat;

    // One CPU access; o_lat is the response cycle counted from acceptance (cycle 0).
    task automatic cpu_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        @(negedge clk);
        cpu_req = 1'b1; cpu_write = wr; cpu_addr = addr; cpu_write_data = wdata;
        n = 0;
        while (!cpu_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 cpu_req = 1'b0;
        o_hit = 0; o_miss = 0; o_got = 0; o_any_req = 0; o_any_write = 0;
        o_rf_addr = 'x; o_rdata = 'x; o_lat = 0;
        n = 0;
        while (!o_got && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                o_c1_req = mem_req; o_c1_write = mem_write;
                o_c1_addr = mem_addr; o_c1_wdata = mem_write_data;
            end
            if (hit) o_hit = 1;
            if (miss) o_miss = 1;
            if (mem_req) o_any_req = 1;
            if (mem_req && mem_write) o_any_write = 1;
            if (mem_req && !mem_write) o_rf_addr = mem_addr;
            if (cpu_rvalid) begin o_got = 1; o_lat = n; o_rdata = cpu_read_data; end
        end
        check("response_seen", 32'(o_got), 32'd1);
    endtask

    initial begin
        int acc_base, rv_base, n;
        mem_model[32'h0000_1000] = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

        repeat (3) @(negedge clk);
        check("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_hit_miss", {30'd0, hit, miss}, 32'd0);
        check("rst_mem_req", {30'd0, mem_req, mem_write}, 32'd0);
        check("rst_rdata", cpu_read_data, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", 32'(|mem_write_data), 32'd0);
        check("rst_counters", hit_count | miss_count | wb_count, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(cpu_ready), 32'd1);

        // Clean load miss with W=3.
        cpu_access(1'b0, 32'h0000_1004, 32'h0);
        check("m1_miss", {30'd0, o_miss, o_hit}, 32'd2);
        check("m1_c1_req", {30'd0, o_c1_req, o_c1_write}, 32'd2);
        check("m1_addr", o_c1_addr, 32'h0000_1000);
        check("m1_rdata", o_rdata, 32'h2222_2222);
        check("m1_latency", 32'(o_lat), 32'd5);

        cpu_access(1'b0, 32'h0000_1008, 32'h0);
        check("h1_hit", {30'd0, o_miss, o_hit}, 32'd1);
        check("h1_rdata", o_rdata, 32'h3333_3333);
        check("h1_latency", 32'(o_lat), 32'd1);

        cpu_access(1'b1, 32'h0000_100C, 32'hDEAD_BEEF);
        check("sh_hit", {30'd0, o_miss, o_hit}, 32'd1);
        check("sh_no_mem", 32'(o_any_req), 32'd0);
        check("sh_latency", 32'(o_lat), 32'd1);

        cpu_access(1'b0, 32'h0000_100C, 32'h0);
        check("raw_rdata", o_rdata, 32'hDEAD_BEEF);

        // Dirty victim eviction.
        cpu_access(1'b0, 32'h0000_5000, 32'h0);
        check("wb_c1_write", {30'd0, o_c1_req, o_c1_write}, 32'd3);
        check("wb_addr", o_c1_addr, 32'h0000_1000);
        check("wb_word3", o_c1_wdata[127:96], 32'hDEAD_BEEF);
        check("wb_refill_addr", o_rf_addr, 32'h0000_5000);
        check("wb_rdata", o_rdata, 32'h0000_5000);
        check("wb_latency", 32'(o_lat), 32'd9);
        check("wb_mem_word3", mem_model[32'h0000_1000][127:96], 32'hDEAD_BEEF);
        check("wb_count1", wb_count, STATS ? 32'd1 : 32'd0);

        // Store miss allocates with a read-only refill.
        cpu_access(1'b1, 32'h0000_2000, 32'h1234_5678);
        check("sm_miss", 32'(o_miss), 32'd1);
        check("sm_no_write", 32'(o_any_write), 32'd0);
        check("sm_refill_addr", o_rf_addr, 32'h0000_2000);
        cpu_access(1'b0, 32'h0000_2000, 32'h0);
        check("sm_load_hit", 32'(o_hit), 32'd1);
        check("sm_load", o_rdata, 32'h1234_5678);
        cpu_access(1'b0, 32'h0000_2004, 32'h0);
        check("sm_neighbour", o_rdata, 32'h0000_2004);

        cpu_access(1'b0, 32'h0000_6000, 32'h0);
        check("sm_dirty_evict", 32'(o_c1_write), 32'd1);
        check("sm_evict_addr", o_c1_addr, 32'h0000_2000);
        check("sm_evict_word0", o_c1_wdata[31:0], 32'h1234_5678);
        check("wb_count2", wb_count, STATS ? 32'd2 : 32'd0);

        // Reset while a refill is outstanding.
        mem_wait = 20;
        @(negedge clk);
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_1004;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rm_req_before", {30'd0, mem_req, mem_write}, 32'd2);
        rv_base = rv_count;
        reset_n = 1'b0;
        #1;
        check("rm_req_dropped", 32'(mem_req), 32'd0);
        check("rm_rvalid", 32'(cpu_rvalid), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mem_wait = 3;
        repeat (25) @(negedge clk);
        check("rm_no_response", 32'(rv_count - rv_base), 32'd0);

        cpu_access(1'b0, 32'h0000_1004, 32'h0);
        check("rm_after_miss", 32'(o_miss), 32'd1);
        check("rm_after_rdata", o_rdata, 32'h2222_2222);

        // Request held through a miss is accepted once.
        acc_base = acc_count;
        @(negedge clk);
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_3000;
        n = 0;
        while (!cpu_rvalid && n < 200) begin @(negedge clk); n++; end
        cpu_req = 1'b0;
        check("hold_rvalid", 32'(cpu_rvalid), 32'd1);
        check("hold_accepts", 32'(acc_count - acc_base), 32'd1);
        check("hold_rdata", cpu_read_data, 32'h0000_3000);

        cpu_access(1'b0, 32'h0000_4000, 32'h0);
        check("m3_rdata", o_rdata, 32'h0000_4000);
        cpu_access(1'b0, 32'h0000_1008, 32'h0);
        check("h2_rdata", o_rdata, 32'h3333_3333);
        cpu_access(1'b0, 32'h0000_3004, 32'h0);
        check("h3_hit", 32'(o_hit), 32'd1);
        check("h3_rdata", o_rdata, 32'h0000_3004);
        @(negedge clk);
        check("cnt_miss", miss_count, STATS ? 32'd3 : 32'd0);
        check("cnt_hit", hit_count, STATS ? 32'd2 : 32'd0);
        check("cnt_wb", wb_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
